wb_stage: RTL
=============

Name: wb_stage

Overview:
- Write-back stage of the ELC3030 8-bit pipeline, directly upstream of the 4-entry register file (R0-R2 GPRs, R3 = SP).
- Takes completed instructions from the memory stage over a valid/ready handshake and holds them in the MEM/WB pipeline register.
- Selects the result source and drives the register file's single write port and its SP increment/decrement controls.
- Sequences two-destination instructions as two consecutive write cycles, because the register file has only one write port.

Parameters:
DATA_W, 8, register/data width
ADDR_W, 2, register address width (4 registers; address 3 = SP)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
in_flush  input  1  squash the pending instruction (branch/interrupt)
in_wr_en  input  1  first destination write requested
in_wr_addr  input  ADDR_W  first destination register
in_src_sel  input  2  first-write source: 0=ALU, 1=memory, 2=immediate, 3=input port
in_alu_res  input  DATA_W  ALU result
in_mem_data  input  DATA_W  memory read data
in_imm  input  DATA_W  immediate byte
in_port_data  input  DATA_W  input-port byte
in_wr2_en  input  1  second destination write requested (dual-write instruction)
in_wr2_addr  input  ADDR_W  second destination register
in_wr2_data  input  DATA_W  second-write data (always taken directly)
in_sp_en  input  1  adjust SP with this instruction
in_sp_op  input  1  SP direction: 0 = decrement (push), 1 = increment (pop)
wr_en  output  1  register file write enable
wr_addr  output  ADDR_W  register file write address
wr_data  output  DATA_W  register file write data
sp_en  output  1  register file SP adjust enable
sp_op  output  1  register file SP direction
sp_conflict  output  1  one-cycle pulse: SP adjust dropped because of an R3 write conflict
fwd_valid  output  1  forwarding entry valid (WB_FWD_EN only)
fwd_addr  output  ADDR_W  forwarding register address
fwd_data  output  DATA_W  forwarding data

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, pipeline register cleared. wr_en, wr_addr, wr_data, sp_en, sp_op, sp_conflict and fwd_* are all 0. in_ready=1 as soon as reset releases.
- States:
  - IDLE: nothing held.
  - W1: first write cycle.
  - W2: second write cycle.
- Accept: transfer occurs on a posedge with in_valid && in_ready && !in_flush.
  - All in_* fields are latched; the source mux is resolved at capture, so only the selected byte is stored.
  - Next state is always W1, even when in_wr_en=0; the instruction still occupies one slot.
- W1: outputs are driven combinationally from the register.
  - wr_en=held wr_en, wr_addr/wr_data = first write, sp_en/sp_op = held values.
  - The register file commits at the next posedge, so latency is one cycle from accept to commit.
  - If wr2_en is held: next state W2, in_ready=0. Otherwise in_ready=1 and next state is W1 on a new accept, else IDLE.
- W2: wr_en=1, wr_addr/wr_data = second write, sp_en=0, in_ready=1. Next state is W1 on a new accept, else IDLE.
- in_ready = !in_flush && !(state==W1 && held wr2_en).
- Throughput: single-write instructions run back-to-back at one per cycle; dual-write instructions take two cycles.
- Same address on both writes: both writes are performed in order, so the second value persists.
- SP conflict: if W1 has wr_en with wr_addr==3 and sp_en=1, sp_en is forced to 0, the R3 write proceeds, and sp_conflict pulses high for that W1 cycle.
- Flush, sampled at posedge:
  - Next state is IDLE and no input is accepted that edge.
  - A W1 or W2 write already being presented that cycle still commits.
  - A pending W2 is cancelled.
- Reset mid-operation: outputs drop to 0 immediately and the pending W2 is lost.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: fwd_valid=wr_en, fwd_addr=wr_addr, fwd_data=wr_data, combinational, so the execute stage can bypass a write that has not yet committed.
- Undefined: fwd_valid, fwd_addr and fwd_data are tied to 0 and no forwarding logic is generated.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0, in_ready=1. Release, present nothing -> outputs stay 0.
- Single write with source select: accept wr_en=1, addr=1, src_sel=1, mem_data=0xBB -> next cycle wr_en=1, wr_addr=1, wr_data=0xBB. Then src_sel=2, imm=0x3C to R2 back-to-back -> 0x3C in the following cycle with no bubble.
- Dual write: accept wr=R0/ALU 0x12 and wr2=R2/0x34 -> W1 writes R0=0x12 with in_ready=0, then W2 writes R2=0x34 with in_ready=1. A queued instruction is accepted only at the end of W2.
- Push/pop: accept sp_en=1, sp_op=0 with wr_en=0 -> sp_en=1, sp_op=0 for one cycle. Accept wr_addr=3, data=0xDD, sp_en=1 -> wr_en=1 to R3 with 0xDD, sp_en=0, sp_conflict=1.
- Flush: during W1 of a dual write (R1 0xAA, R2 0x55) assert in_flush -> R1=0xAA commits, no R2 write, state IDLE, and an in_valid on the flush edge is not accepted.
- With WB_FWD_EN defined: fwd_valid/addr/data mirror wr_en/addr/data in every W1/W2 cycle. Undefined: they stay 0 throughout all tests.

Source files
------------

// File: rtl/wb_stage_if.sv
// Memory-stage handshake and register-file write port bundle for the write-back stage.
// master = memory stage / register-file side, slave = wb_stage.
interface wb_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic              in_flush;
  logic              in_wr_en;
  logic [ADDR_W-1:0] in_wr_addr;
  logic [1:0]        in_src_sel;
  logic [DATA_W-1:0] in_alu_res;
  logic [DATA_W-1:0] in_mem_data;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] in_port_data;
  logic              in_wr2_en;
  logic [ADDR_W-1:0] in_wr2_addr;
  logic [DATA_W-1:0] in_wr2_data;
  logic              in_sp_en;
  logic              in_sp_op;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              sp_en;
  logic              sp_op;
  logic              sp_conflict;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output in_valid, in_flush, in_wr_en, in_wr_addr, in_src_sel, in_alu_res,
           in_mem_data, in_imm, in_port_data, in_wr2_en, in_wr2_addr,
           in_wr2_data, in_sp_en, in_sp_op,
    input  in_ready, wr_en, wr_addr, wr_data, sp_en, sp_op, sp_conflict,
           fwd_valid, fwd_addr, fwd_data
  );

  modport slave (
    input  in_valid, in_flush, in_wr_en, in_wr_addr, in_src_sel, in_alu_res,
           in_mem_data, in_imm, in_port_data, in_wr2_en, in_wr2_addr,
           in_wr2_data, in_sp_en, in_sp_op,
    output in_ready, wr_en, wr_addr, wr_data, sp_en, sp_op, sp_conflict,
           fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, result mux, single-port write sequencing (W1/W2).
// Optional macro WB_FWD_EN exposes the not-yet-committed write as a forwarding entry.
module wb_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input logic      clk,
  input logic      rst_n,
  wb_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, W1, W2} state_t;

  typedef struct packed {
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr2_en;
    logic [ADDR_W-1:0] wr2_addr;
    logic [DATA_W-1:0] wr2_data;
    logic              sp_en;
    logic              sp_op;
  } mw_t;

  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(3);

  state_t            state_q, state_d;
  mw_t               mw_q, mw_d;
  logic              in_ready, accept, r3_conflict;
  logic [DATA_W-1:0] src_byte;
  logic              wr_en, sp_en, sp_op, sp_conflict;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Source is resolved at capture so only one byte needs holding.
  always_comb begin
    src_byte = bus.in_alu_res;
    case (bus.in_src_sel)
      2'd1:    src_byte = bus.in_mem_data;
      2'd2:    src_byte = bus.in_imm;
      2'd3:    src_byte = bus.in_port_data;
      default: src_byte = bus.in_alu_res;
    endcase
  end

  assign in_ready = !bus.in_flush && !(state_q == W1 && mw_q.wr2_en);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    mw_d = mw_q;
    if (accept) begin
      mw_d.wr_en    = bus.in_wr_en;
      mw_d.wr_addr  = bus.in_wr_addr;
      mw_d.wr_data  = src_byte;
      mw_d.wr2_en   = bus.in_wr2_en;
      mw_d.wr2_addr = bus.in_wr2_addr;
      mw_d.wr2_data = bus.in_wr2_data;
      mw_d.sp_en    = bus.in_sp_en;
      mw_d.sp_op    = bus.in_sp_op;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (!bus.in_flush) begin
      case (state_q)
        W1:      state_d = mw_q.wr2_en ? W2 : (accept ? W1 : IDLE);
        default: state_d = accept ? W1 : IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mw_q    <= '0;
    end else begin
      state_q <= state_d;
      mw_q    <= mw_d;
    end
  end

  // An R3 write and an SP adjust in the same cycle would race; the write wins.
  assign r3_conflict = mw_q.wr_en && (mw_q.wr_addr == SP_ADDR) && mw_q.sp_en;

  always_comb begin
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    sp_en       = 1'b0;
    sp_op       = 1'b0;
    sp_conflict = 1'b0;
    case (state_q)
      W1: begin
        wr_en       = mw_q.wr_en;
        wr_addr     = mw_q.wr_addr;
        wr_data     = mw_q.wr_data;
        sp_en       = mw_q.sp_en && !r3_conflict;
        sp_op       = mw_q.sp_op;
        sp_conflict = r3_conflict;
      end
      W2: begin
        wr_en   = 1'b1;
        wr_addr = mw_q.wr2_addr;
        wr_data = mw_q.wr2_data;
      end
      default: ;
    endcase
  end

  assign bus.in_ready    = in_ready;
  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = wr_addr;
  assign bus.wr_data     = wr_data;
  assign bus.sp_en       = sp_en;
  assign bus.sp_op       = sp_op;
  assign bus.sp_conflict = sp_conflict;

`ifdef WB_FWD_EN
  assign bus.fwd_valid = wr_en;
  assign bus.fwd_addr  = wr_addr;
  assign bus.fwd_data  = wr_data;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_addr  = '0;
  assign bus.fwd_data  = '0;
`endif
endmodule
